// File: rtl/apb_pkg.sv
// Shared types and constants for the APB slave memory block.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned CNT_W      = 4;

endpackage

// File: rtl/apb_slave_regfile.sv
// Storage array for apb_slave_mem: one synchronous write port,
// one asynchronous read port and a synchronous clear of every word.
module apb_slave_regfile #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Clear all words on reset, otherwise commit the write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave with a small word memory and a programmable number of wait states.
// Optional macro APB_SLAVE_PSLVERR_EN: addresses beyond DEPTH complete with
// pslverr=1, writes suppressed and reads returning 0; without it addresses wrap.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic              pready,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  addr_q;
  logic              wr_q;
  logic              err_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] prdata_q;
  logic [DATA_W-1:0] rd_data;
  logic              oor;
  logic              mem_we;
  logic              access_ok;

`ifdef APB_SLAVE_PSLVERR_EN
  assign oor = (paddr >> IDX_W) != '0;
`else
  logic unused_addr_hi;
  assign oor            = 1'b0;
  assign unused_addr_hi = ^(paddr >> IDX_W);
`endif

  assign access_ok = psel && penable;
  assign pready    = (state_q == ACCESS) && (cnt_q == '0);
  assign mem_we    = pready && access_ok && wr_q && !err_q;
  assign prdata    = prdata_q;

`ifdef APB_SLAVE_PSLVERR_EN
  assign pslverr = pready && err_q;
`else
  assign pslverr = 1'b0;
`endif

  apb_slave_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we),
    .waddr_i (addr_q),
    .wdata_i (wdata_q),
    .raddr_i (paddr[IDX_W-1:0]),
    .rdata_o (rd_data)
  );

  // Transfer FSM: capture on setup, count wait states, complete or abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      prdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (psel && !penable) begin
            state_q  <= ACCESS;
            cnt_q    <= CNT_W'(WAIT_CYCLES);
            addr_q   <= paddr[IDX_W-1:0];
            wr_q     <= pwrite;
            err_q    <= oor;
            wdata_q  <= pwdata;
            prdata_q <= (!pwrite && !oor) ? rd_data : '0;
          end
        end
        ACCESS: begin
          if (!access_ok) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            prdata_q <= '0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q  <= IDLE;
            prdata_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
